// File: rtl/oto_wb_regs.sv
// ---------------------------------------------------------------------------
// oto_wb_regs
//
// Wishbone-slave register window for an autopilot sensor/actuator bridge.
// The host writes a sensor word that is driven into the autopilot and can
// switch the autopilot over to that word. The block also watches the three
// autopilot actuator outputs. For those outputs it keeps a live status
// copy, sticky rising-edge flags and a saturating edge counter on bit 0. It
// raises a level interrupt when any flag is set and interrupts are enabled.
//
// Register window (256 bytes at BASE_ADDR, word offsets):
//   0x00 CTRL   RW  bit0 OVR, bit1 IRQ_EN
//   0x04 SENSOR RW  [18:0] -> pilot_in_o
//   0x08 STATUS RO  [2:0]  synchronized pilot_out_i
//   0x0C EVENT  W1C [2:0]  sticky rising-edge flags
//   0x10 CNT    WC  [15:0] rising edges of pilot_out_i[0], saturating
//   other offsets ack, read 0, ignore writes
//
// Ports:
//   clock, reset      sole clock (rising edge), synchronous active-high reset
//   wbs_*             Wishbone classic slave, one-cycle ack, no wait states
//   pilot_in_o        sensor word towards the autopilot
//   pilot_ovr_o       1 = autopilot uses pilot_in_o instead of its pads
//   pilot_out_i       autopilot actuator outputs (asynchronous to clock)
//   irq_o             registered level interrupt
// ---------------------------------------------------------------------------
module oto_wb_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [18:0] pilot_in_o,
  output logic        pilot_ovr_o,
  input  logic [2:0]  pilot_out_i,
  output logic        irq_o
);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_SENSOR = 6'h01;
  localparam logic [5:0] OFF_STATUS = 6'h02;
  localparam logic [5:0] OFF_EVENT  = 6'h03;
  localparam logic [5:0] OFF_CNT    = 6'h04;

  // Bus decode
  logic       hit;
  logic       req;
  logic       wr;
  logic       rd;
  logic [5:0] offset;

  // State
  logic        ack_reg;
  logic [31:0] dat_reg,    dat_next;
  logic [1:0]  ctrl_reg,   ctrl_next;
  logic [18:0] sensor_reg, sensor_next;
  logic [2:0]  sync1_reg;
  logic [2:0]  sync2_reg;
  logic [2:0]  sync_prev_reg;
  logic [2:0]  event_reg,  event_next;
  logic [15:0] cnt_reg,    cnt_next;
  logic        irq_reg;

  logic [2:0]  pilot_edge;
  logic [2:0]  event_clr;
  logic [31:0] rd_data;

  // Address bits below the word offset and data bits above the widest
  // register carry no meaning for this window.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:19], wbs_sel_i[3]};

  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset = wbs_adr_i[7:2];
  // The ~ack term stops a still-asserted strobe in the ack cycle from
  // being taken as a second request.
  assign req    = wbs_cyc_i & wbs_stb_i & hit & ~ack_reg;
  assign wr     = req &  wbs_we_i;
  assign rd     = req & ~wbs_we_i;

  // Per-bit edge detect on the synchronized actuator outputs. Each EVENT
  // flag is set by its edge and cleared by a written 1. The edge is ORed
  // in last, so a new edge wins over a clear in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_evt
      assign pilot_edge[gi] = sync2_reg[gi] & ~sync_prev_reg[gi];
      assign event_next[gi] = (event_reg[gi] & ~event_clr[gi]) | pilot_edge[gi];
    end
  endgenerate

  always_comb begin
    event_clr = 3'b000;
    if (wr && (offset == OFF_EVENT) && wbs_sel_i[0]) begin
      event_clr = wbs_dat_i[2:0];
    end
  end

  always_comb begin
    ctrl_next = ctrl_reg;
    if (wr && (offset == OFF_CTRL) && wbs_sel_i[0]) begin
      ctrl_next = wbs_dat_i[1:0];
    end
  end

  always_comb begin
    sensor_next = sensor_reg;
    if (wr && (offset == OFF_SENSOR)) begin
      if (wbs_sel_i[0]) sensor_next[7:0]   = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) sensor_next[15:8]  = wbs_dat_i[15:8];
      if (wbs_sel_i[2]) sensor_next[18:16] = wbs_dat_i[18:16];
    end
  end

  // Any write to CNT clears it, whatever the data and lanes. An edge in
  // the same cycle is counted on top of the clear, so the result is 1.
  always_comb begin
    cnt_next = cnt_reg;
    if (wr && (offset == OFF_CNT)) begin
      cnt_next = {15'd0, pilot_edge[0]};
    end else if (pilot_edge[0] && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (offset)
      OFF_CTRL:   rd_data = {30'd0, ctrl_reg};
      OFF_SENSOR: rd_data = {13'd0, sensor_reg};
      OFF_STATUS: rd_data = {29'd0, sync2_reg};
      OFF_EVENT:  rd_data = {29'd0, event_reg};
      OFF_CNT:    rd_data = {16'd0, cnt_reg};
      default:    rd_data = 32'd0;
    endcase
  end

  // Read data is captured when the request is accepted. It is visible only
  // in the single ack cycle and returns to zero afterwards.
  always_comb begin
    dat_next = 32'd0;
    if (rd) begin
      dat_next = rd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_reg       <= 1'b0;
      dat_reg       <= 32'd0;
      ctrl_reg      <= 2'b00;
      sensor_reg    <= 19'd0;
      sync1_reg     <= 3'b000;
      sync2_reg     <= 3'b000;
      sync_prev_reg <= 3'b000;
      event_reg     <= 3'b000;
      cnt_reg       <= 16'd0;
      irq_reg       <= 1'b0;
    end else begin
      ack_reg       <= req;
      dat_reg       <= dat_next;
      ctrl_reg      <= ctrl_next;
      sensor_reg    <= sensor_next;
      sync1_reg     <= pilot_out_i;
      sync2_reg     <= sync1_reg;
      sync_prev_reg <= sync2_reg;
      event_reg     <= event_next;
      cnt_reg       <= cnt_next;
      irq_reg       <= ctrl_reg[1] & (|event_reg);
    end
  end

  assign wbs_ack_o   = ack_reg;
  assign wbs_dat_o   = dat_reg;
  assign pilot_in_o  = sensor_reg;
  assign pilot_ovr_o = ctrl_reg[0];
  assign irq_o       = irq_reg;

endmodule

// File: tb/tb_oto_wb_regs.sv
// ---------------------------------------------------------------------------
// tb_oto_wb_regs
//
// Directed bench for oto_wb_regs. Bus tasks push the expected read word
// into a queue when a transfer is issued. A monitor on the falling edge
// pops one entry per ack and compares it with the returned data. Side-band
// outputs (pilot_in_o, pilot_ovr_o, irq_o) are checked inline.
// ---------------------------------------------------------------------------
module tb_oto_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [18:0] pilot_in_o;
  logic        pilot_ovr_o;
  logic [2:0]  pilot_out_i = 3'b000;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  oto_wb_regs #(.BASE_ADDR(BASE)) dut (
    .clock       (clock),
    .reset       (reset),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .pilot_in_o  (pilot_in_o),
    .pilot_ovr_o (pilot_ovr_o),
    .pilot_out_i (pilot_out_i),
    .irq_o       (irq_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard monitor: one pop per ack. Data must be zero outside ack.
  always @(negedge clock) begin
    exp_t e;
    if (wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_ack: got ack=1 adr=%h expected no ack", wbs_adr_i);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check(e.name, wbs_dat_o, e.exp);
        else $display("[TB] ack  %s", e.name);
      end
    end else if (wbs_dat_o !== 32'd0) begin
      tests++;
      fails++;
      $display("[TB] FAIL dat_idle: got %h expected 00000000", wbs_dat_o);
    end
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issue one transfer and wait (bounded) for its ack. Returns 1 time
  // unit after the accepting edge, with the strobe already dropped.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [31:0] exp, input string name);
    exp_t e;
    logic got;
    e.chk = ~we;
    e.exp = exp;
    e.name = name;
    exp_q.push_back(e);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock);
      #1;
      if (wbs_ack_o) got = 1'b1;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no ack expected ack within 8 cycles", name);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel,
                    input string name);
    bus(1'b1, BASE + {24'd0, off}, dat, sel, 32'd0, name);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    bus(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, exp, name);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  initial begin
    int acks;

    // Reset state
    do_reset();
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_pilot_in", {13'd0, pilot_in_o}, 32'd0);
    check("rst_ovr", {31'd0, pilot_ovr_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    rd(8'h00, 32'd0, "rst_ctrl");
    rd(8'h04, 32'd0, "rst_sensor");
    rd(8'h0C, 32'd0, "rst_event");
    rd(8'h10, 32'd0, "rst_cnt");

    // SENSOR full write: only 19 bits exist
    wr(8'h04, 32'hFFFF_FFFF, 4'hF, "wr_sensor_all");
    check("pilot_in_all", {13'd0, pilot_in_o}, 32'h0007_FFFF);
    rd(8'h04, 32'h0007_FFFF, "rd_sensor_all");

    // SENSOR byte-lane writes
    do_reset();
    wr(8'h04, 32'h0001_2345, 4'b0001, "wr_sensor_lane0");
    rd(8'h04, 32'h0000_0045, "rd_sensor_lane0");
    wr(8'h04, 32'h00AB_0000, 4'b0100, "wr_sensor_lane2");
    rd(8'h04, 32'h0003_0045, "rd_sensor_lane2");
    check("pilot_in_lane", {13'd0, pilot_in_o}, 32'h0003_0045);

    // CTRL
    wr(8'h00, 32'hFFFF_FFFF, 4'hF, "wr_ctrl_all");
    rd(8'h00, 32'h0000_0003, "rd_ctrl_all");
    check("ovr_on", {31'd0, pilot_ovr_o}, 32'd1);
    wr(8'h00, 32'h0000_0002, 4'h1, "wr_ctrl_irqen");
    check("ovr_off", {31'd0, pilot_ovr_o}, 32'd0);

    // Rising edge on bit0: EVENT/CNT after 3 edges, irq after 4
    tick(1);
    pilot_out_i = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check($sformatf("irq_edge_plus%0d", k), {31'd0, irq_o}, (k >= 4) ? 32'd1 : 32'd0);
    end
    rd(8'h08, 32'h0000_0001, "rd_status_1");
    rd(8'h0C, 32'h0000_0001, "rd_event_1");
    rd(8'h10, 32'h0000_0001, "rd_cnt_1");
    wr(8'h0C, 32'h0000_0001, 4'h1, "wr_event_clr");
    check("irq_clr_same", {31'd0, irq_o}, 32'd1);
    tick(1);
    check("irq_clr_next", {31'd0, irq_o}, 32'd0);

    // Bits 1 and 2, W1C per bit, lane 0 gating
    pilot_out_i = 3'b111;
    tick(5);
    rd(8'h0C, 32'h0000_0006, "rd_event_6");
    rd(8'h10, 32'h0000_0001, "rd_cnt_still1");
    rd(8'h08, 32'h0000_0007, "rd_status_7");
    wr(8'h0C, 32'h0000_0002, 4'h1, "wr_event_clr1");
    rd(8'h0C, 32'h0000_0004, "rd_event_4");
    wr(8'h0C, 32'h0000_0007, 4'b1110, "wr_event_nosel");
    rd(8'h0C, 32'h0000_0004, "rd_event_nosel");
    pilot_out_i = 3'b011;
    tick(4);
    wr(8'h0C, 32'h0000_0004, 4'h1, "wr_event_clr2");
    rd(8'h0C, 32'h0000_0000, "rd_event_0");

    // Clear coincident with a new edge on bit2: set wins
    pilot_out_i = 3'b111;
    tick(2);
    wr(8'h0C, 32'h0000_0004, 4'h1, "wr_event_race");
    rd(8'h0C, 32'h0000_0004, "rd_event_race");

    // CNT saturation, preloaded just below the limit
    pilot_out_i = 3'b110;
    tick(4);
    force dut.cnt_reg = 16'hFFFE;
    #1;
    release dut.cnt_reg;
    tick(1);
    pilot_out_i = 3'b111;
    tick(4);
    rd(8'h10, 32'h0000_FFFF, "rd_cnt_ffff");
    pilot_out_i = 3'b110;
    tick(4);
    pilot_out_i = 3'b111;
    tick(4);
    rd(8'h10, 32'h0000_FFFF, "rd_cnt_sat");
    pilot_out_i = 3'b110;
    tick(4);
    pilot_out_i = 3'b111;
    tick(2);
    wr(8'h10, 32'h0000_0000, 4'h0, "wr_cnt_race");
    rd(8'h10, 32'h0000_0001, "rd_cnt_race");
    wr(8'h10, 32'h1234_5678, 4'hF, "wr_cnt_clr");
    rd(8'h10, 32'h0000_0000, "rd_cnt_clr");

    // Unmapped offset inside the window
    wr(8'h20, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
    rd(8'h20, 32'h0000_0000, "rd_unmapped");
    rd(8'h00, 32'h0000_0002, "rd_ctrl_kept");

    // Outside the window: never acked
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 32'h3000_0100;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    check("no_ack_outside", acks, 32'd0);

    // Reset while a CTRL write is pending
    tick(1);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = BASE;
    wbs_dat_i = 32'h0000_0003;
    wbs_sel_i = 4'hF;
    reset     = 1'b1;
    tick(1);
    check("rst_mid_ack", {31'd0, wbs_ack_o}, 32'd0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    reset     = 1'b0;
    tick(1);
    check("rst_mid_ack2", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_mid_ovr", {31'd0, pilot_ovr_o}, 32'd0);
    rd(8'h00, 32'h0000_0000, "rst_mid_ctrl");

    tick(2);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL pending_acks: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oto_wb_regs.md
OTO_WB_REGS -- requirements
Module: oto_wb_regs

Interface
REQ-001 Parameter BASE_ADDR SHALL be: BASE_ADDR, default 32'h3000_0000, base of the 256-byte register window.
REQ-002 Port clock SHALL be: clock  input  1  sole clock; all flops rising-edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port wbs_cyc_i SHALL be: wbs_cyc_i  input  1  Wishbone cycle.
REQ-005 Port wbs_stb_i SHALL be: wbs_stb_i  input  1  Wishbone strobe.
REQ-006 Port wbs_we_i SHALL be: wbs_we_i  input  1  1 = write.
REQ-007 Port wbs_sel_i SHALL be: wbs_sel_i  input  4  byte-lane enables.
REQ-008 Port wbs_adr_i SHALL be: wbs_adr_i  input  32  byte address.
REQ-009 Port wbs_dat_i SHALL be: wbs_dat_i  input  32  write data.
REQ-010 Port wbs_ack_o SHALL be: wbs_ack_o  output  1  transfer acknowledge.
REQ-011 Port wbs_dat_o SHALL be: wbs_dat_o  output  32  read data.
REQ-012 Port pilot_in_o SHALL be: pilot_in_o  output  19  sensor word driven to autopilot inputs.
REQ-013 Port pilot_ovr_o SHALL be: pilot_ovr_o  output  1  1 = autopilot takes pilot_in_o instead of pads.
REQ-014 Port pilot_out_i SHALL be: pilot_out_i  input  3  autopilot actuator outputs, asynchronous to clock.
REQ-015 Port irq_o SHALL be: irq_o  output  1  level interrupt.

Function
REQ-016 Block SHALL decode a hit when wbs_adr_i[31:8] == BASE_ADDR[31:8]; offset = wbs_adr_i[7:2].
REQ-017 Hit with cyc & stb & ~ack SHALL raise wbs_ack_o the next cycle, for exactly one cycle; one-cycle latency, no wait states.
REQ-018 Non-hit SHALL never ack; wbs_dat_o SHALL be 0 whenever wbs_ack_o is 0.
REQ-019 Write SHALL take effect on the ack cycle; only lanes with wbs_sel_i set update.
REQ-020 Register map: 0x00 CTRL RW, bit0 OVR, bit1 IRQ_EN, others read 0.
REQ-021 Register map: 0x04 SENSOR RW [18:0], drives pilot_in_o directly; bits 31:19 read 0.
REQ-022 Register map: 0x08 STATUS RO [2:0] = synchronized pilot_out_i.
REQ-023 Register map: 0x0C EVENT [2:0], sticky rising-edge flags, write-1-to-clear.
REQ-024 Register map: 0x10 CNT [15:0], rising edges of synchronized pilot_out_i[0]; saturates at 16'hFFFF; any write clears it, regardless of data/sel.
REQ-025 Unmapped offsets SHALL ack, read 0, and ignore writes.
REQ-026 pilot_ovr_o SHALL equal CTRL.OVR.
REQ-027 pilot_out_i SHALL pass a 2-flop synchronizer; edge = sync & ~sync_prev; STATUS reflects input change 2 cycles later.
REQ-028 EVENT bit / CNT SHALL update 3 cycles after the input rise.
REQ-029 EVENT W1C in same cycle as new edge on that bit: set wins (bit stays 1).
REQ-030 CNT write in same cycle as edge: result 1.
REQ-031 irq_o SHALL be registered: irq_o <= IRQ_EN & |EVENT.
REQ-032 Read data SHALL be sampled at request acceptance and held only during ack.

Reset
REQ-033 reset (synchronous) SHALL force: wbs_ack_o=0, wbs_dat_o=0, CTRL=0, SENSOR=0, pilot_in_o=0, pilot_ovr_o=0, EVENT=0, CNT=0, irq_o=0, synchronizer flops=0.
REQ-034 Reset asserted mid-transfer SHALL drop any pending ack next cycle; the write SHALL NOT take effect; the master SHALL re-issue it.

Verification
REQ-035 Write 0x3000_0004 = 32'hFFFF_FFFF, sel=4'hF -> ack 1 cycle later; pilot_in_o=19'h7FFFF; read returns 32'h0007_FFFF.
REQ-036 Write SENSOR 32'h0001_2345 sel=4'b0001 after reset -> read 32'h0000_0045.
REQ-037 Pulse pilot_out_i[0] 0->1 -> STATUS bit0=1 at +2, EVENT=3'b001 and CNT=1 at +3; with IRQ_EN=1, irq_o=1 at +4; write EVENT=1 -> irq_o=0 next-but-one cycle.
REQ-038 Preload 65535 edges -> CNT=16'hFFFF; one more edge -> stays FFFF; write CNT coincident with edge -> reads 1.
REQ-039 Access at 0x3000_0100 -> no ack within 16 cycles; read at 0x3000_0020 -> ack, data 0.
REQ-040 Assert reset during ack-pending write to CTRL=3 -> no ack, CTRL reads 0, pilot_ovr_o=0.
